// File: rtl/eth_pkg.sv
// Shared types and constants for the Ethernet RMII receive path.
// Also holds the two-bit reflected CRC-32 step used by the FCS checker.
package eth_pkg;

    typedef enum logic [2:0] {
        IDLE,
        PRE,
        DAT,
        EOP,
        ERR
    } rx_state_t;

    localparam logic [31:0] CRC32_RESIDUE = 32'hDEBB20E3;
    localparam logic [31:0] CRC32_POLY    = 32'hEDB88320;

    // Reflected CRC-32 advanced by one RMII dibit, bit 0 first as on the wire.
    function automatic logic [31:0] crc32_dibit(input logic [31:0] crc,
                                                input logic [1:0]  d);
        logic [31:0] r;
        r = crc;
        for (int i = 0; i < 2; i++) begin
            r = (r[0] ^ d[i]) ? ((r >> 1) ^ CRC32_POLY) : (r >> 1);
        end
        return r;
    endfunction

endpackage

// File: rtl/eth_crc32_2.sv
// Running Ethernet CRC-32 register fed two bits per enable.
// A clear coinciding with an enable folds the first dibit into a fresh seed.
module eth_crc32_2
    import eth_pkg::*;
(
    input  logic        clk50,
    input  logic        rst_n,
    input  logic        clr,
    input  logic        en,
    input  logic [1:0]  d,
    output logic [31:0] crc
);

    logic [31:0] base;

    assign base = clr ? 32'hFFFF_FFFF : crc;

    always_ff @(posedge clk50 or negedge rst_n) begin
        if (!rst_n) begin
            crc <= 32'hFFFF_FFFF;
        end else if (en) begin
            crc <= crc32_dibit(base, d);
        end else begin
            crc <= base;
        end
    end

endmodule

// File: rtl/eth_rmii_rx_mac.sv
// RMII receive MAC front end: 10/100 sample strobe, preamble/SFD qualification,
// byte assembly, length count and per-frame status snapshot on eop.
module eth_rmii_rx_mac
    import eth_pkg::*;
#(
    parameter int MIN_LEN = 64,
    parameter int MAX_LEN = 1518,
    parameter int PRE_MIN = 3,
    parameter int LEN_W   = 11
) (
    input  logic             clk50,
    input  logic             rst_n,
    input  logic             speed100,
    input  logic [1:0]       rx,
    input  logic             crs_dv,
    output logic [7:0]       data,
    output logic             valid,
    output logic             sop,
    output logic             eop,
    output logic [LEN_W-1:0] len,
    output logic             crc_ok,
    output logic             err_runt,
    output logic             err_giant,
    output logic             err_align
);

    localparam logic [LEN_W-1:0] MIN_L     = LEN_W'(MIN_LEN);
    localparam logic [LEN_W-1:0] MAX_L     = LEN_W'(MAX_LEN);
    localparam logic [LEN_W-1:0] LEN_SAT   = '1;
    localparam logic [3:0]       PRE_MIN_C = 4'(PRE_MIN);

    rx_state_t   state, state_nx;
    logic        spd_q;
    logic [3:0]  div;
    logic        smp;
    logic [3:0]  pre_cnt;
    logic [1:0]  dib;
    logic        dv_low_q;
    logic        byte_done_q;
    logic        good_q;
    logic        align_q;
    logic [31:0] crc;

    logic go_pre, pre_inc, sfd, shift, byte_end, frame_end, align_end;

    assign smp = spd_q || (div == 4'd0);

    // NOTE: every signal driven here gets a default first, so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        state_nx  = state;
        go_pre    = 1'b0;
        pre_inc   = 1'b0;
        sfd       = 1'b0;
        shift     = 1'b0;
        byte_end  = 1'b0;
        frame_end = 1'b0;
        align_end = 1'b0;
        case (state)
            IDLE: begin
                if (smp && crs_dv && rx == 2'b01) begin
                    state_nx = PRE;
                    go_pre   = 1'b1;
                end
            end
            PRE: begin
                if (smp) begin
                    if (crs_dv && rx == 2'b01) begin
                        pre_inc = 1'b1;
                    end else if (crs_dv && rx == 2'b11 && pre_cnt >= PRE_MIN_C) begin
                        state_nx = DAT;
                        sfd      = 1'b1;
                    end else begin
                        state_nx = ERR;
                    end
                end
            end
            DAT: begin
                if (smp) begin
                    shift    = 1'b1;
                    byte_end = (dib == 2'd3);
                    // CRS_DV is only meaningful on odd dibits (CR/DV multiplex).
                    if (!crs_dv && dib[0]) begin
                        state_nx  = EOP;
                        frame_end = 1'b1;
                        align_end = (dib == 2'd1);
                    end
                end
            end
            EOP: begin
                state_nx = IDLE;
            end
            ERR: begin
                if (smp && !crs_dv && dv_low_q) begin
                    state_nx = IDLE;
                end
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    // NOTE: sequential state is written with non-blocking assignments only, so
    // every register samples pre-edge values regardless of statement order.
    always_ff @(posedge clk50 or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_ff @(posedge clk50 or negedge rst_n) begin
        if (!rst_n) begin
            spd_q       <= 1'b0;
            div         <= 4'd0;
            pre_cnt     <= 4'd0;
            dib         <= 2'd0;
            dv_low_q    <= 1'b0;
            byte_done_q <= 1'b0;
            good_q      <= 1'b0;
            align_q     <= 1'b0;
            data        <= 8'd0;
            valid       <= 1'b0;
            sop         <= 1'b0;
            eop         <= 1'b0;
            len         <= '0;
            crc_ok      <= 1'b0;
            err_runt    <= 1'b0;
            err_giant   <= 1'b0;
            err_align   <= 1'b0;
        end else begin
            valid       <= 1'b0;
            sop         <= 1'b0;
            eop         <= 1'b0;
            byte_done_q <= 1'b0;

            if (go_pre) begin
                div <= 4'd0;
            end else begin
                div <= (div == 4'd9) ? 4'd0 : div + 4'd1;
            end

            if (state == IDLE) begin
                spd_q <= speed100;
            end

            if (smp) begin
                dv_low_q <= !crs_dv;
            end

            if (go_pre) begin
                pre_cnt <= 4'd0;
            end else if (pre_inc && pre_cnt != 4'hF) begin
                pre_cnt <= pre_cnt + 4'd1;
            end

            if (sfd) begin
                sop       <= 1'b1;
                dib       <= 2'd0;
                len       <= '0;
                crc_ok    <= 1'b0;
                err_runt  <= 1'b0;
                err_giant <= 1'b0;
                err_align <= 1'b0;
                good_q    <= 1'b0;
                align_q   <= 1'b0;
            end

            if (shift) begin
                data <= {rx, data[7:2]};
                dib  <= dib + 2'd1;
            end

            // Bytes past MAX_LEN are still counted and CRC'd, just not emitted.
            if (byte_end) begin
                byte_done_q <= 1'b1;
                if (len < MAX_L) begin
                    valid <= 1'b1;
                end
                if (len != LEN_SAT) begin
                    len <= len + LEN_W'(1);
                end
            end

            if (byte_done_q) begin
                good_q <= (crc == CRC32_RESIDUE);
            end

            if (frame_end) begin
                align_q <= align_end;
            end

            if (state == EOP) begin
                eop       <= 1'b1;
                data      <= 8'd0;
                crc_ok    <= byte_done_q ? (crc == CRC32_RESIDUE) : good_q;
                err_runt  <= (len < MIN_L);
                err_giant <= (len > MAX_L);
                err_align <= align_q;
            end
        end
    end

    eth_crc32_2 u_crc (
        .clk50 (clk50),
        .rst_n (rst_n),
        .clr   (sop),
        .en    (shift),
        .d     (rx),
        .crc   (crc)
    );

endmodule

// File: tb/tb_eth_rmii_rx_mac.sv
// Directed bench for eth_rmii_rx_mac: good/bad FCS, 10M timing, bad preamble,
// runt/giant/alignment status and mid-frame reset recovery.
module tb_eth_rmii_rx_mac;

    localparam int          LEN_W = 11;
    localparam logic [31:0] POLY  = 32'hEDB88320;

    logic             clk50    = 1'b0;
    logic             rst_n    = 1'b1;
    logic             speed100 = 1'b1;
    logic [1:0]       rx       = 2'b00;
    logic             crs_dv   = 1'b0;
    logic [7:0]       data;
    logic             valid, sop, eop;
    logic [LEN_W-1:0] len;
    logic             crc_ok, err_runt, err_giant, err_align;

    eth_rmii_rx_mac dut (
        .clk50     (clk50),
        .rst_n     (rst_n),
        .speed100  (speed100),
        .rx        (rx),
        .crs_dv    (crs_dv),
        .data      (data),
        .valid     (valid),
        .sop       (sop),
        .eop       (eop),
        .len       (len),
        .crc_ok    (crc_ok),
        .err_runt  (err_runt),
        .err_giant (err_giant),
        .err_align (err_align)
    );

    always #10 clk50 = ~clk50;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int hold    = 1;
    int sop_cnt = 0;
    int eop_cnt = 0;
    int sop_cyc = 0;
    logic [7:0]       frm[$];
    logic [7:0]       cap[$];
    int               vcyc[$];
    logic [LEN_W+3:0] eop_stat = '0;

    always @(posedge clk50) cyc <= cyc + 1;

    always @(negedge clk50) begin
        if (valid) begin
            cap.push_back(data);
            vcyc.push_back(cyc);
        end
        if (sop) begin
            sop_cnt++;
            sop_cyc = cyc;
        end
        if (eop) begin
            eop_cnt++;
            eop_stat = {len, crc_ok, err_runt, err_giant, err_align};
        end
    end

    // Payload of n-4 bytes followed by the standard Ethernet FCS; flip >= 0 corrupts one byte.
    task automatic build_frame(input int n, input int flip);
        logic [31:0] c;
        frm.delete();
        for (int i = 0; i < n - 4; i++) frm.push_back(8'((i * 37 + 11) ^ (i >> 3)));
        c = 32'hFFFF_FFFF;
        for (int i = 0; i < n - 4; i++) begin
            c = c ^ {24'd0, frm[i]};
            for (int b = 0; b < 8; b++) c = c[0] ? ((c >> 1) ^ POLY) : (c >> 1);
        end
        c = ~c;
        for (int k = 0; k < 4; k++) frm.push_back(c[8*k +: 8]);
        if (flip >= 0) frm[flip] = frm[flip] ^ 8'h10;
    endtask

    task automatic send_dibit(input logic [1:0] d, input logic dv);
        rx     = d;
        crs_dv = dv;
        repeat (hold) @(negedge clk50);
    endtask

    // tail: 0 = normal end, 1 = two trailing dibits (misaligned), 2 = stop mid-frame
    task automatic send_frame(input int nb, input int tail);
        logic [7:0] b;
        logic       last;
        for (int i = 0; i < 31; i++) send_dibit(2'b01, 1'b1);
        send_dibit(2'b11, 1'b1);
        for (int i = 0; i < nb; i++) begin
            b = frm[i];
            for (int k = 0; k < 4; k++) begin
                last = (tail == 0) && (i == nb - 1) && (k == 3);
                send_dibit(b[2*k +: 2], !last);
            end
        end
        if (tail == 1) begin
            send_dibit(2'b10, 1'b1);
            send_dibit(2'b01, 1'b0);
        end
        if (tail != 2) repeat (4) send_dibit(2'b00, 1'b0);
    endtask

    task automatic clear_capture();
        cap.delete();
        vcyc.delete();
    endtask

    task automatic test_reset();
        #5 rst_n = 1'b0;
        repeat (3) @(negedge clk50);
        n_tests++;
        if ({valid, sop, eop, data, len, crc_ok, err_runt, err_giant, err_align} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: got valid=%b sop=%b eop=%b data=%h len=%0d crc_ok=%b errs=%b%b%b, expected all 0",
                     valid, sop, eop, data, len, crc_ok, err_runt, err_giant, err_align);
        end
        rst_n = 1'b1;
        repeat (5) @(negedge clk50);
        n_tests++;
        if (sop_cnt != 0 || eop_cnt != 0 || cap.size() != 0) begin
            n_fail++;
            $display("FAIL reset_idle: got sop=%0d eop=%0d valids=%0d, expected 0 0 0", sop_cnt, eop_cnt, cap.size());
        end
    endtask

    task automatic test_good_100m();
        int s0, e0, bad;
        build_frame(64, -1);
        clear_capture();
        s0 = sop_cnt;
        e0 = eop_cnt;
        send_frame(64, 0);
        n_tests++;
        if (sop_cnt - s0 != 1) begin
            n_fail++;
            $display("FAIL good_sop_count: got %0d, expected 1", sop_cnt - s0);
        end
        n_tests++;
        if (cap.size() != 64) begin
            n_fail++;
            $display("FAIL good_valid_count: got %0d, expected 64", cap.size());
        end
        bad = 0;
        for (int i = 0; i < cap.size() && i < frm.size(); i++) if (cap[i] !== frm[i]) bad++;
        n_tests++;
        if (bad != 0) begin
            n_fail++;
            $display("FAIL good_bytes: got %0d mismatching bytes, expected 0", bad);
        end
        bad = 0;
        for (int i = 1; i < vcyc.size(); i++) if (vcyc[i] - vcyc[i-1] != 4) bad++;
        n_tests++;
        if (bad != 0 || vcyc.size() == 0 || vcyc[0] - sop_cyc != 4) begin
            n_fail++;
            $display("FAIL good_timing: got %0d bad gaps, sop->valid %0d, expected 0 gaps, 4",
                     bad, (vcyc.size() > 0) ? vcyc[0] - sop_cyc : -1);
        end
        n_tests++;
        if (eop_cnt - e0 != 1 || eop_stat !== {11'd64, 4'b1000}) begin
            n_fail++;
            $display("FAIL good_eop_status: got eops=%0d stat=%h, expected 1 %h", eop_cnt - e0, eop_stat, {11'd64, 4'b1000});
        end
        n_tests++;
        if ({len, crc_ok, err_runt, err_giant, err_align} !== {11'd64, 4'b1000}) begin
            n_fail++;
            $display("FAIL good_status_held: got len=%0d crc_ok=%b errs=%b%b%b, expected 64 1 000",
                     len, crc_ok, err_runt, err_giant, err_align);
        end
    endtask

    task automatic test_bad_crc();
        int e0;
        build_frame(64, 10);
        clear_capture();
        e0 = eop_cnt;
        send_frame(64, 0);
        n_tests++;
        if (cap.size() != 64 || eop_cnt - e0 != 1) begin
            n_fail++;
            $display("FAIL badcrc_counts: got valids=%0d eops=%0d, expected 64 1", cap.size(), eop_cnt - e0);
        end
        n_tests++;
        if (eop_stat !== {11'd64, 4'b0000}) begin
            n_fail++;
            $display("FAIL badcrc_status: got %h, expected %h", eop_stat, {11'd64, 4'b0000});
        end
    endtask

    task automatic test_10m();
        int bad, e0;
        speed100 = 1'b0;
        repeat (5) send_dibit(2'b00, 1'b0);
        hold = 10;
        build_frame(64, -1);
        clear_capture();
        e0 = eop_cnt;
        send_frame(64, 0);
        bad = 0;
        for (int i = 1; i < vcyc.size(); i++) if (vcyc[i] - vcyc[i-1] != 40) bad++;
        n_tests++;
        if (cap.size() != 64 || bad != 0) begin
            n_fail++;
            $display("FAIL 10m_valids: got %0d valids, %0d bad gaps, expected 64, 0", cap.size(), bad);
        end
        bad = 0;
        for (int i = 0; i < cap.size() && i < frm.size(); i++) if (cap[i] !== frm[i]) bad++;
        n_tests++;
        if (bad != 0) begin
            n_fail++;
            $display("FAIL 10m_bytes: got %0d mismatching bytes, expected 0", bad);
        end
        n_tests++;
        if (eop_cnt - e0 != 1 || eop_stat !== {11'd64, 4'b1000}) begin
            n_fail++;
            $display("FAIL 10m_status: got eops=%0d stat=%h, expected 1 %h", eop_cnt - e0, eop_stat, {11'd64, 4'b1000});
        end
        hold     = 1;
        speed100 = 1'b1;
        repeat (5) send_dibit(2'b00, 1'b0);
    endtask

    task automatic test_bad_preamble();
        int s0, e0;
        clear_capture();
        s0 = sop_cnt;
        e0 = eop_cnt;
        send_dibit(2'b01, 1'b1);
        send_dibit(2'b01, 1'b1);
        send_dibit(2'b00, 1'b1);
        repeat (17) send_dibit(2'b00, 1'b1);
        repeat (10) send_dibit(2'b00, 1'b0);
        n_tests++;
        if (sop_cnt != s0 || eop_cnt != e0 || cap.size() != 0) begin
            n_fail++;
            $display("FAIL badpre_silent: got sop=%0d eop=%0d valids=%0d, expected 0 0 0",
                     sop_cnt - s0, eop_cnt - e0, cap.size());
        end
        build_frame(64, -1);
        clear_capture();
        send_frame(64, 0);
        n_tests++;
        if (cap.size() != 64 || eop_stat !== {11'd64, 4'b1000}) begin
            n_fail++;
            $display("FAIL badpre_recover: got valids=%0d stat=%h, expected 64 %h", cap.size(), eop_stat, {11'd64, 4'b1000});
        end
    endtask

    task automatic test_len_errors();
        build_frame(40, -1);
        clear_capture();
        send_frame(40, 0);
        n_tests++;
        if (cap.size() != 40 || eop_stat !== {11'd40, 4'b1100}) begin
            n_fail++;
            $display("FAIL runt: got valids=%0d stat=%h, expected 40 %h", cap.size(), eop_stat, {11'd40, 4'b1100});
        end
        build_frame(1600, -1);
        clear_capture();
        send_frame(1600, 0);
        n_tests++;
        if (cap.size() != 1518) begin
            n_fail++;
            $display("FAIL giant_valids: got %0d, expected 1518", cap.size());
        end
        n_tests++;
        if (eop_stat[LEN_W+3:4] !== 11'd1600 || eop_stat[2:0] !== 3'b010) begin
            n_fail++;
            $display("FAIL giant_status: got len=%0d errs=%b, expected 1600 010", eop_stat[LEN_W+3:4], eop_stat[2:0]);
        end
        build_frame(64, -1);
        clear_capture();
        send_frame(64, 1);
        n_tests++;
        if (cap.size() != 64 || eop_stat !== {11'd64, 4'b1001}) begin
            n_fail++;
            $display("FAIL align: got valids=%0d stat=%h, expected 64 %h", cap.size(), eop_stat, {11'd64, 4'b1001});
        end
    endtask

    task automatic test_reset_midframe();
        int e0;
        build_frame(64, -1);
        clear_capture();
        e0 = eop_cnt;
        send_frame(20, 2);
        n_tests++;
        if (len !== 11'd20) begin
            n_fail++;
            $display("FAIL midframe_len: got %0d, expected 20", len);
        end
        #2 rst_n = 1'b0;
        #1;
        n_tests++;
        if ({valid, sop, eop, data, len, crc_ok, err_runt, err_giant, err_align} !== '0) begin
            n_fail++;
            $display("FAIL midreset_outputs: got data=%h len=%0d valid=%b, expected all 0", data, len, valid);
        end
        rx     = 2'b00;
        crs_dv = 1'b0;
        repeat (3) @(negedge clk50);
        rst_n = 1'b1;
        repeat (10) send_dibit(2'b00, 1'b0);
        n_tests++;
        if (eop_cnt != e0) begin
            n_fail++;
            $display("FAIL midreset_no_eop: got %0d eops, expected 0", eop_cnt - e0);
        end
        clear_capture();
        send_frame(64, 0);
        n_tests++;
        if (cap.size() != 64 || eop_cnt - e0 != 1 || eop_stat !== {11'd64, 4'b1000}) begin
            n_fail++;
            $display("FAIL midreset_recover: got valids=%0d eops=%0d stat=%h, expected 64 1 %h",
                     cap.size(), eop_cnt - e0, eop_stat, {11'd64, 4'b1000});
        end
    endtask

    initial begin
        test_reset();
        test_good_100m();
        test_bad_crc();
        test_10m();
        test_bad_preamble();
        test_len_errors();
        test_reset_midframe();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
